// File: rtl/bb_byte_feeder.sv
// bb_byte_feeder
// ---------------
// Byte source for the DVB-S2 8PSK modulator. Host payload bytes are buffered
// in a small FIFO. On every single-cycle next_data request the block presents
// exactly one new byte on `data`:
//   - the sync byte at frame position 0,
//   - otherwise the FIFO head, if the FIFO holds a byte,
//   - otherwise a pad byte, which is counted in underflow_cnt.
// Because of the pad byte the modulator never stalls.
//
// Ports
//   clk            single clock (same clock as the modulator top)
//   rst            synchronous, active-high reset
//   s_data/s_valid host payload byte and its valid flag
//   s_ready        FIFO can accept a byte (!full)
//   next_data      one-cycle request: consume the presented byte
//   frame_sync     one-cycle request: realign to frame position 0
//   data           presented byte, registered, stable between advances
//   sof            high while `data` is the sync byte (position 0)
//   level          FIFO occupancy, 0..DEPTH
//   underflow_cnt  number of pad bytes issued, saturating
module bb_byte_feeder #(
  parameter int          DEPTH       = 16,
  parameter int          FRAME_BYTES = 8100,
  parameter logic [7:0]  SYNC_BYTE   = 8'hB8,
  parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       next_data,
  input  logic                       frame_sync,
  output logic [7:0]                 data,
  output logic                       sof,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                underflow_cnt
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          PW       = AW + 1;
  localparam logic [15:0] LAST_POS = 16'(FRAME_BYTES - 1);

  // FIFO storage. It has no reset, so it can map onto plain memory.
  logic [7:0]    mem [DEPTH];

  logic [PW-1:0] wptr_reg, wptr_next;
  logic [PW-1:0] rptr_reg, rptr_next;
  logic [15:0]   pos_reg, pos_next;
  logic [7:0]    data_reg, data_next;
  logic          sof_reg, sof_next;
  logic [15:0]   ucnt_reg, ucnt_next;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [15:0]   pos_adv;

  // The pointers carry one extra wrap bit.
  // When the wrap bits differ and the address bits match, the FIFO has lapped
  // itself, so it is full.
  assign full  = (wptr_reg[PW-1] != rptr_reg[PW-1]) &&
                 (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
  assign empty = (wptr_reg == rptr_reg);

  // s_ready comes only from registered pointers.
  // Therefore a pop in the same cycle cannot make room for a push at full.
  assign push  = s_valid && !full;

  // Frame position that the next advance would move to.
  assign pos_adv = (pos_reg == LAST_POS) ? 16'd0 : pos_reg + 16'd1;

  always_comb begin
    pos_next  = pos_reg;
    data_next = data_reg;
    ucnt_next = ucnt_reg;
    pop       = 1'b0;

    if (frame_sync) begin
      // A realignment wins over a coincident next_data request.
      // That request is dropped: no pop and no pad count.
      pos_next  = 16'd0;
      data_next = SYNC_BYTE;
    end else if (next_data) begin
      pos_next = pos_adv;
      if (pos_adv == 16'd0) begin
        data_next = SYNC_BYTE;
      end else if (!empty) begin
        // empty uses the pointers from before this cycle's push.
        // So a byte written in this cycle is never bypassed to the output.
        data_next = mem[rptr_reg[AW-1:0]];
        pop       = 1'b1;
      end else begin
        data_next = PAD_BYTE;
        if (ucnt_reg != 16'hFFFF) begin
          ucnt_next = ucnt_reg + 16'd1;
        end
      end
    end

    sof_next  = (pos_next == 16'd0);
    wptr_next = wptr_reg + PW'(push);
    rptr_next = rptr_reg + PW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
      pos_reg  <= 16'd0;
      data_reg <= SYNC_BYTE;
      sof_reg  <= 1'b1;
      ucnt_reg <= 16'd0;
    end else begin
      wptr_reg <= wptr_next;
      rptr_reg <= rptr_next;
      pos_reg  <= pos_next;
      data_reg <= data_next;
      sof_reg  <= sof_next;
      ucnt_reg <= ucnt_next;
    end
  end

  // Memory write port.
  // It is gated by rst so that a push in the reset cycle leaves no trace.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wptr_reg[AW-1:0]] <= s_data;
    end
  end

  assign s_ready       = !full;
  assign data          = data_reg;
  assign sof           = sof_reg;
  assign level         = wptr_reg - rptr_reg;
  assign underflow_cnt = ucnt_reg;

endmodule

// File: tb/tb_bb_byte_feeder.sv
// Bench for bb_byte_feeder.
// FRAME_BYTES is set to 4 so that frame wrap-around shows up quickly.
// Each advance pushes its expected byte and sof onto a scoreboard queue.
// The entry is popped and compared after the clock edge.
module tb_bb_byte_feeder;
  localparam int         DEPTH = 16;
  localparam int         FB    = 4;
  localparam logic [7:0] SYNC  = 8'hB8;
  localparam logic [7:0] PAD   = 8'h00;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        next_data = 1'b0;
  logic        frame_sync = 1'b0;
  logic [7:0]  data;
  logic        sof;
  logic [4:0]  level;
  logic [15:0] underflow_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [7:0] mq[$];
  logic [8:0] sb[$];
  int         m_pos;
  int         m_ucnt;
  logic [7:0] m_data;
  logic       m_sof;

  always #5 clk = ~clk;

  bb_byte_feeder #(
    .DEPTH(DEPTH), .FRAME_BYTES(FB), .SYNC_BYTE(SYNC), .PAD_BYTE(PAD)
  ) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .next_data(next_data), .frame_sync(frame_sync),
    .data(data), .sof(sof), .level(level), .underflow_cnt(underflow_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_status();
    check("level", 32'(level), 32'(mq.size()));
    check("s_ready", 32'(s_ready), 32'(mq.size() < DEPTH));
    check("underflow_cnt", 32'(underflow_cnt), 32'(m_ucnt));
  endtask

  // Run one clock cycle with the given inputs.
  // The model is advanced with the same inputs.
  task automatic cycle(input bit pv, input logic [7:0] pd, input bit nd, input bit fs);
    logic [7:0] exp_d;
    logic [8:0] e;
    int  pos_n;
    bit  adv;
    bit  acc;
    exp_d = PAD;
    adv = 1'b0;
    // The full test uses the occupancy before this cycle's pop.
    acc = pv && (mq.size() < DEPTH);
    if (fs) begin
      m_pos = 0;
      exp_d = SYNC;
      adv = 1'b1;
    end else if (nd) begin
      pos_n = (m_pos == FB - 1) ? 0 : m_pos + 1;
      m_pos = pos_n;
      adv = 1'b1;
      if (pos_n == 0) begin
        exp_d = SYNC;
      end else if (mq.size() > 0) begin
        exp_d = mq.pop_front();
      end else begin
        exp_d = PAD;
        if (m_ucnt != 65535) m_ucnt++;
      end
    end
    if (adv) sb.push_back({(m_pos == 0), exp_d});
    // The push lands after the empty test, so it is never bypassed.
    if (acc) mq.push_back(pd);

    s_valid = pv;
    s_data = pd;
    next_data = nd;
    frame_sync = fs;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    next_data = 1'b0;
    frame_sync = 1'b0;

    if (adv) begin
      e = sb.pop_front();
      m_data = e[7:0];
      m_sof = e[8];
      $display("adv: data=%02h sof=%0b (expect %02h %0b) level=%0d ucnt=%0d",
               data, sof, m_data, m_sof, level, underflow_cnt);
      check("adv_data", 32'(data), 32'(m_data));
      check("adv_sof", 32'(sof), 32'(m_sof));
    end else begin
      check("hold_data", 32'(data), 32'(m_data));
      check("hold_sof", 32'(sof), 32'(m_sof));
    end
    check_status();
  endtask

  // Hold reset for 2 cycles.
  // In the first reset cycle a request and a push are pending; both must be ignored.
  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b1;
    s_data = 8'hEE;
    next_data = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    next_data = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    sb.delete();
    m_pos = 0;
    m_ucnt = 0;
    m_data = SYNC;
    m_sof = 1'b1;
    $display("reset: data=%02h sof=%0b level=%0d s_ready=%0b ucnt=%0d",
             data, sof, level, s_ready, underflow_cnt);
    check("rst_data", 32'(data), 32'(SYNC));
    check("rst_sof", 32'(sof), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_ucnt", 32'(underflow_cnt), 32'd0);
  endtask

  initial begin
    do_reset();

    // Ordered payload; the requests are 32 clocks apart.
    cycle(1, 8'h11, 0, 0);
    cycle(1, 8'h22, 0, 0);
    cycle(1, 8'h33, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 8'h00, 1, 0);
      repeat (31) cycle(0, 8'h00, 0, 0);
    end

    // Frame wrap with back-to-back requests.
    do_reset();
    for (int b = 1; b <= 6; b++) cycle(1, 8'(b), 0, 0);
    for (int i = 0; i < 7; i++) cycle(0, 8'h00, 1, 0);

    // Underflow. A push in the same cycle as a request is not bypassed.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 1);
    cycle(1, 8'hA5, 1, 0);
    cycle(0, 8'h00, 1, 0);

    // Full, with s_valid held. Then one pop refills a single slot.
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1, 8'(8'h40 + i), 0, 0);
    cycle(1, 8'h60, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'(8'h61 + i), 0, 0);
    for (int i = 0; i < 24; i++) cycle(0, 8'h00, 1, 0);

    // A reset with data still buffered.
    cycle(1, 8'h77, 0, 0);
    do_reset();

    // frame_sync in mid-frame together with next_data.
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 1, 0);
    cycle(1, 8'hC1, 0, 0);
    cycle(1, 8'hC2, 0, 0);
    cycle(0, 8'h00, 1, 1);
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
